gray_to_bin_rx: RTL and testbench

//  Receive-side decoder for the Gray-coded, inverted bit stream produced by our transmit encoder.

---
 rtl/gray_to_bin_rx.sv | 120 ++++++++++++
 tb/tb_gray_to_bin_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_bin_rx.sv
// gray_to_bin_rx: receive-side decoder for the inverted Gray-coded stream.
// Stage 1 re-inverts and captures the code and checks its Hamming distance
// to the previous accepted code. Stage 2 converts Gray to binary and keeps
// the step-error count. Both stages use valid/ready handshakes.
module gray_to_bin_rx #(
    parameter int W          = 4,
    parameter bit INVERT_IN  = 1'b1,
    parameter bit ALLOW_HOLD = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_gray,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_bin,
    output logic         out_step,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         clr_err,
    output logic [7:0]   err_cnt,
    output logic         sticky_err
);

    // Number of set bits; W is at most 16, so 5 bits are enough.
    function automatic logic [4:0] popcount(input logic [W-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < W; i++) n = n + {4'b0, v[i]};
        return n;
    endfunction

    // Prefix XOR from the MSB downwards.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Counter increment that sticks at full scale.
    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic         adv1, adv2;
    logic [W-1:0] g_p0;
    logic [4:0]   hd_p0;
    logic         step_p0, acc_p0;
    logic [W-1:0] prev_gray;
    logic         have_prev;

    logic [W-1:0] g_p1;
    logic         step_p1, vld_p1;

    logic [W-1:0] bin_p2;
    logic         step_p2, vld_p2;

    // ---- stage 0: input side, distance check against the previous code ----
    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = adv1;
    assign acc_p0   = in_valid && adv1;
    assign g_p0     = INVERT_IN ? ~in_gray : in_gray;
    assign hd_p0    = popcount(g_p0 ^ prev_gray);
    assign step_p0  = have_prev && ((hd_p0 > 5'd1) || ((hd_p0 == 5'd0) && !ALLOW_HOLD));

    // ---- stage 1: captured code and step flag ----
    // Stage-1 control and the previous-code tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            have_prev <= 1'b0;
            prev_gray <= '0;
        end else begin
            if (adv1)   vld_p1    <= in_valid;
            if (acc_p0) prev_gray <= g_p0;
            // A cleared tracker makes the next accepted word a fresh start.
            if (clr_err)     have_prev <= 1'b0;
            else if (acc_p0) have_prev <= 1'b1;
        end
    end

    // Stage-1 data; only meaningful while vld_p1 is set.
    always_ff @(posedge clk) begin
        if (adv1) begin
            g_p1    <= g_p0;
            step_p1 <= step_p0;
        end
    end

    // ---- stage 2: binary word, step flag and error accounting ----
    // Stage-2 output registers; they hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            bin_p2  <= '0;
            step_p2 <= 1'b0;
        end else if (adv2) begin
            vld_p2  <= vld_p1;
            bin_p2  <= gray2bin(g_p1);
            step_p2 <= step_p1;
        end
    end

    // Error counter and sticky flag; a clear wins over a same-cycle error.
    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_cnt    <= 8'd0;
            sticky_err <= 1'b0;
        end else if (adv2 && vld_p1 && step_p1) begin
            err_cnt    <= sat_inc8(err_cnt);
            sticky_err <= 1'b1;
        end
    end

    assign out_bin   = bin_p2;
    assign out_step  = step_p2;
    assign out_valid = vld_p2;

endmodule

// File: tb/tb_gray_to_bin_rx.sv
// Directed bench for gray_to_bin_rx. Two instances share every input: one
// with the default parameters and one with ALLOW_HOLD=0.
module tb_gray_to_bin_rx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_gray;
    logic         in_valid;
    logic         out_ready;
    logic         clr_err;

    logic         in_ready,  in_ready_nh;
    logic [W-1:0] out_bin,   out_bin_nh;
    logic         out_step,  out_step_nh;
    logic         out_valid, out_valid_nh;
    logic [7:0]   err_cnt,   err_cnt_nh;
    logic         sticky_err, sticky_err_nh;

    int n_chk  = 0;
    int n_fail = 0;

    // Gray codes of 0..15; the binary value of GRAY[i] is i.
    logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    gray_to_bin_rx #(.W(W), .INVERT_IN(1'b1), .ALLOW_HOLD(1'b1)) dut (
        .clk(clk), .rst(rst), .in_gray(in_gray), .in_valid(in_valid),
        .in_ready(in_ready), .out_bin(out_bin), .out_step(out_step),
        .out_valid(out_valid), .out_ready(out_ready), .clr_err(clr_err),
        .err_cnt(err_cnt), .sticky_err(sticky_err)
    );

    gray_to_bin_rx #(.W(W), .INVERT_IN(1'b1), .ALLOW_HOLD(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .in_gray(in_gray), .in_valid(in_valid),
        .in_ready(in_ready_nh), .out_bin(out_bin_nh), .out_step(out_step_nh),
        .out_valid(out_valid_nh), .out_ready(out_ready), .clr_err(clr_err),
        .err_cnt(err_cnt_nh), .sticky_err(sticky_err_nh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one Gray code, wait for it to leave stage 2, check both instances.
    task automatic send_one(input logic [3:0] g, input logic [3:0] eb,
                            input logic es_h, input logic es_nh, input string tag);
        int n;
        out_ready = 1'b1;
        in_gray   = ~g;
        in_valid  = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_acc"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_vld"},     32'(out_valid),   32'd1);
        check({tag, "_bin"},     32'(out_bin),     32'(eb));
        check({tag, "_step"},    32'(out_step),    32'(es_h));
        check({tag, "_bin_nh"},  32'(out_bin_nh),  32'(eb));
        check({tag, "_step_nh"}, 32'(out_step_nh), 32'(es_nh));
        tick();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        int sent, rcv;
        logic fire_in, fire_out, was_stalled;
        logic [3:0] held;

        rst = 1'b1; in_gray = 4'h0; in_valid = 1'b1; out_ready = 1'b1; clr_err = 1'b0;

        // 1: reset held two cycles with in_valid asserted
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        check("rst_sticky",    32'(sticky_err), 32'd0);
        check("rst_out_bin",   32'(out_bin),   32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 2: decode 0..15 back to back
        for (int j = 0; j <= 16; j++) begin
            in_valid = (j < 16);
            in_gray  = ~GRAY[j % 16];
            tick();
            if (j == 0) begin
                check("dec_latency", 32'(out_valid), 32'd0);
            end else begin
                check("dec_vld",  32'(out_valid), 32'd1);
                check("dec_bin",  32'(out_bin),   32'(j - 1));
                check("dec_step", 32'(out_step),  32'd0);
            end
        end
        in_valid = 1'b0;
        tick();

        // 3: eight codes with out_ready low for five cycles mid-stream
        sent = 0; rcv = 0; was_stalled = 1'b0; held = 4'h0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            out_ready = !(c >= 3 && c < 8);
            in_valid  = (sent < 8);
            in_gray   = ~GRAY[sent % 16];
            #1;
            check("bp_in_ready", 32'(in_ready), 32'(((sent - rcv) < 2) || out_ready));
            if (was_stalled) check("bp_hold", 32'(out_bin), 32'(held));
            if (out_valid) begin
                check("bp_data", 32'(out_bin),  32'(rcv));
                check("bp_step", 32'(out_step), 32'd0);
            end
            fire_in     = in_valid && in_ready;
            fire_out    = out_valid && out_ready;
            was_stalled = out_valid && !out_ready;
            held        = out_bin;
            @(posedge clk);
            #1;
            if (fire_in)  sent++;
            if (fire_out) rcv++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(rcv), 32'd8);

        // 4: step error and recovery, then repeated code
        pulse_clr();
        check("clr_cnt0", 32'(err_cnt), 32'd0);
        send_one(4'b0001, 4'b0001, 1'b0, 1'b0, "st_first");
        send_one(4'b0111, 4'b0101, 1'b1, 1'b1, "st_hd2");
        check("st_err_cnt", 32'(err_cnt),    32'd1);
        check("st_sticky",  32'(sticky_err), 32'd1);
        send_one(4'b0101, 4'b0110, 1'b0, 1'b0, "st_hd1");
        send_one(4'b0111, 4'b0101, 1'b0, 1'b0, "st_hd1b");
        send_one(4'b0011, 4'b0010, 1'b0, 1'b0, "hold_a");
        send_one(4'b0011, 4'b0010, 1'b0, 1'b1, "hold_b");
        check("hold_err_cnt",    32'(err_cnt),    32'd1);
        check("hold_err_cnt_nh", 32'(err_cnt_nh), 32'd2);

        // 5: saturation after 300 errors, then clear
        pulse_clr();
        check("sat_clr0", 32'(err_cnt_nh), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            in_valid = 1'b1;
            in_gray  = (k % 2 == 1) ? ~4'b0011 : ~4'b0000;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("sat_cnt",    32'(err_cnt),    32'd255);
        check("sat_cnt_nh", 32'(err_cnt_nh), 32'd255);
        check("sat_sticky", 32'(sticky_err), 32'd1);
        pulse_clr();
        check("clr_cnt",    32'(err_cnt),    32'd0);
        check("clr_sticky", 32'(sticky_err), 32'd0);

        // 6: reset with two words queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_gray   = ~4'b0000;
        tick();
        in_gray   = ~4'b0001;
        tick();
        in_valid  = 1'b0;
        #1;
        check("q_in_ready",  32'(in_ready),  32'd0);
        check("q_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_out_bin",   32'(out_bin),   32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("mrst_drained", 32'(out_valid), 32'd0);
        send_one(4'b1111, 4'b1010, 1'b0, 1'b0, "mrst_first");
        check("mrst_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
